// File: rtl/wave_fetch_scheduler_pkg.sv
// Shared definitions for the wavefront fetch scheduler: slot counts, id and
// credit widths, and the enabled id-to-one-hot decoder used by the top level.
package wave_fetch_scheduler_pkg;

    localparam int WF_PER_CU    = 40;
    localparam int WF_ID_LENGTH = 6;
    localparam int CREDIT_W     = 4;

    // Enabled 6-to-40 decoder; ids beyond the last slot decode to all zeros.
    function automatic logic [WF_PER_CU-1:0] dec_6to40(input logic en,
                                                       input logic [WF_ID_LENGTH-1:0] id);
        logic [WF_PER_CU-1:0] oh;
        oh = '0;
        if (en && (int'(id) < WF_PER_CU)) oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wave_fetch_scheduler_if.sv
// Fetch request channel between the scheduler (master) and the fetch unit (slave),
// including the credit return strobe from the fetch unit.
interface wave_fetch_scheduler_if;

    logic                                            fetch_valid;
    logic [wave_fetch_scheduler_pkg::WF_ID_LENGTH-1:0] fetch_wfid;
    logic                                            fetch_ready;
    logic                                            fetch_return_en;

    modport master (output fetch_valid, fetch_wfid, input fetch_ready, fetch_return_en);
    modport slave  (input fetch_valid, fetch_wfid, output fetch_ready, fetch_return_en);

endinterface

// File: rtl/wave_fetch_scheduler_picker.sv
// Round-robin priority picker over the 40 wavefront slots: rotate the eligible
// vector down by rr_ptr, find the lowest set bit, then map back to a slot id.
module rr_priority_picker_40
    import wave_fetch_scheduler_pkg::*;
(
    input  logic [WF_PER_CU-1:0]    eligible,
    input  logic [WF_ID_LENGTH-1:0] rr_ptr,
    output logic [WF_ID_LENGTH-1:0] winner,
    output logic                    hit
);

    logic [WF_PER_CU-1:0]    rot;
    logic [WF_ID_LENGTH-1:0] k;
    logic [WF_ID_LENGTH:0]   sum;

    always_comb begin
        rot = WF_PER_CU'({eligible, eligible} >> rr_ptr);
        k   = '0;
        hit = 1'b0;
        for (int i = WF_PER_CU - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k   = WF_ID_LENGTH'(i);
                hit = 1'b1;
            end
        end
        // rr_ptr is always a valid slot, so one subtraction completes the modulo.
        sum = {1'b0, rr_ptr} + {1'b0, k};
        if (sum >= (WF_ID_LENGTH + 1)'(WF_PER_CU)) sum = sum - (WF_ID_LENGTH + 1)'(WF_PER_CU);
        winner = sum[WF_ID_LENGTH-1:0];
    end

endmodule

// File: rtl/wave_fetch_scheduler.sv
// Collects per-wavefront fetch requests into a pending bitmap and issues one
// round-robin winner at a time on the fetch channel, bounded by a credit count.
module wave_fetch_scheduler
    import wave_fetch_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WF_PER_CU-1:0]    wave_valid_entries,
    input  logic                    dispatch_en,
    input  logic [WF_ID_LENGTH-1:0] dispatch_wfid,
    input  logic                    dealloc_en,
    input  logic [WF_ID_LENGTH-1:0] dealloc_wfid,
    wave_fetch_scheduler_if.master  fetch_bus,
    output logic [WF_PER_CU-1:0]    pending_bitmap,
    output logic                    credit_err
);

    logic [WF_PER_CU-1:0]    pending;
    logic                    fetch_valid;
    logic [WF_ID_LENGTH-1:0] fetch_wfid;
    logic [CREDIT_W-1:0]     credits;
    logic [WF_ID_LENGTH-1:0] rr_ptr;
    logic                    err;

    logic                    accept;
    logic                    ret;
    logic [WF_PER_CU-1:0]    set_vec;
    logic [WF_PER_CU-1:0]    acc_oh;
    logic [WF_PER_CU-1:0]    dealloc_oh;
    logic [WF_PER_CU-1:0]    eligible;
    logic [WF_ID_LENGTH-1:0] winner;
    logic                    hit;
    logic [CREDIT_W-1:0]     credits_left;
    logic                    load;
    logic                    withdraw;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_OUTSTANDING);

    assign accept     = fetch_valid & fetch_bus.fetch_ready;
    assign ret        = fetch_bus.fetch_return_en;
    assign set_vec    = wave_valid_entries | dec_6to40(dispatch_en, dispatch_wfid);
    assign acc_oh     = dec_6to40(accept, fetch_wfid);
    assign dealloc_oh = dec_6to40(dealloc_en, dealloc_wfid);
    // The wavefront sitting in the output register must not be picked twice.
    assign eligible   = pending & ~dec_6to40(fetch_valid, fetch_wfid);

    rr_priority_picker_40 u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .hit      (hit)
    );

    // A slot freed by this cycle's accept is already usable for the next load.
    assign credits_left = credits - CREDIT_W'(accept);
    assign load         = (~fetch_valid | accept) & hit & (credits_left != '0);
    assign withdraw     = dealloc_en & (dealloc_wfid == fetch_wfid) & fetch_valid
                          & ~fetch_bus.fetch_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            fetch_valid <= 1'b0;
            fetch_wfid  <= '0;
            credits     <= CREDIT_MAX;
            rr_ptr      <= '0;
            err         <= 1'b0;
        end else begin
            pending <= ((pending & ~acc_oh) | set_vec) & ~dealloc_oh;

            if (load) begin
                fetch_valid <= 1'b1;
                fetch_wfid  <= winner;
                rr_ptr      <= (winner == WF_ID_LENGTH'(WF_PER_CU - 1)) ? '0 : winner + 1'b1;
            end else if (accept || withdraw) begin
                fetch_valid <= 1'b0;
            end

            if (accept && !ret) begin
                credits <= credits - 1'b1;
            end else if (!accept && ret) begin
                if (credits == CREDIT_MAX) err <= 1'b1;
                else                       credits <= credits + 1'b1;
            end
        end
    end

    assign fetch_bus.fetch_valid = fetch_valid;
    assign fetch_bus.fetch_wfid  = fetch_wfid;
    assign pending_bitmap        = pending;
    assign credit_err            = err;

endmodule

// File: tb/tb_wave_fetch_scheduler.sv
// Directed bench for wave_fetch_scheduler: reset, dispatch latency, round-robin
// order, stall/withdraw, credit throttling, same-cycle re-request and credit_err.
module tb_wave_fetch_scheduler;
    import wave_fetch_scheduler_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [WF_PER_CU-1:0]    wave_valid_entries;
    logic                    dispatch_en;
    logic [WF_ID_LENGTH-1:0] dispatch_wfid;
    logic                    dealloc_en;
    logic [WF_ID_LENGTH-1:0] dealloc_wfid;
    logic [WF_PER_CU-1:0]    pending_bitmap;
    logic                    credit_err;
    int                      checks = 0;
    int                      errors = 0;

    wave_fetch_scheduler_if fif ();

    wave_fetch_scheduler #(.MAX_OUTSTANDING(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .wave_valid_entries (wave_valid_entries),
        .dispatch_en        (dispatch_en),
        .dispatch_wfid      (dispatch_wfid),
        .dealloc_en         (dealloc_en),
        .dealloc_wfid       (dealloc_wfid),
        .fetch_bus          (fif.master),
        .pending_bitmap     (pending_bitmap),
        .credit_err         (credit_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        wave_valid_entries  = '0;
        dispatch_en         = 1'b0;
        dispatch_wfid       = '0;
        dealloc_en          = 1'b0;
        dealloc_wfid        = '0;
        fif.fetch_return_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Dirty the state first: a presented request and a sticky error.
        rst = 1'b0;
        fif.fetch_ready = 1'b0;
        dispatch_en = 1'b1; dispatch_wfid = 6'd9;
        tick();
        dispatch_en = 1'b0;
        fif.fetch_return_en = 1'b1;
        tick();
        fif.fetch_return_en = 1'b0;
        do_reset();
        checks++;
        if (fif.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", fif.fetch_valid); end
        checks++;
        if (fif.fetch_wfid !== 6'd0) begin errors++; $display("FAIL reset_wfid: got %0d expected 0", fif.fetch_wfid); end
        checks++;
        if (pending_bitmap !== 40'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending_bitmap); end
        checks++;
        if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %0b expected 0", credit_err); end
    endtask

    task automatic test_dispatch();
        int cnt;
        do_reset();
        fif.fetch_ready = 1'b1;
        dispatch_en = 1'b1; dispatch_wfid = 6'd5;
        tick();
        dispatch_en = 1'b0;
        checks++;
        if (pending_bitmap !== 40'h20 || fif.fetch_valid !== 1'b0) begin
            errors++; $display("FAIL dispatch_pending: got %h/%0b expected 20/0", pending_bitmap, fif.fetch_valid);
        end
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd5) begin
            errors++; $display("FAIL dispatch_grant: got %0b/%0d expected 1/5", fif.fetch_valid, fif.fetch_wfid);
        end
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b0 || pending_bitmap !== 40'h0) begin
            errors++; $display("FAIL dispatch_clear: got %0b/%h expected 0/0", fif.fetch_valid, pending_bitmap);
        end
        // Three credits remain, so six new requests yield exactly three grants.
        cnt = 0;
        wave_valid_entries = 40'h3F;
        for (int i = 0; i < 10; i++) begin
            tick();
            wave_valid_entries = '0;
            if (fif.fetch_valid && fif.fetch_ready) cnt++;
        end
        checks++;
        if (cnt != 3) begin errors++; $display("FAIL dispatch_credit_left: got %0d grants expected 3", cnt); end
    endtask

    task automatic test_rr_order();
        do_reset();
        fif.fetch_ready = 1'b1;
        dispatch_en = 1'b1; dispatch_wfid = 6'd10;
        tick();
        dispatch_en = 1'b0;
        tick();
        tick();
        wave_valid_entries = (40'h1 << 3) | (40'h1 << 10) | (40'h1 << 39);
        tick();
        wave_valid_entries = '0;
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd39) begin
            errors++; $display("FAIL rr_first: got %0b/%0d expected 1/39", fif.fetch_valid, fif.fetch_wfid);
        end
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd3) begin
            errors++; $display("FAIL rr_second: got %0b/%0d expected 1/3", fif.fetch_valid, fif.fetch_wfid);
        end
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd10) begin
            errors++; $display("FAIL rr_third: got %0b/%0d expected 1/10", fif.fetch_valid, fif.fetch_wfid);
        end
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b0 || pending_bitmap !== 40'h0) begin
            errors++; $display("FAIL rr_drain: got %0b/%h expected 0/0", fif.fetch_valid, pending_bitmap);
        end
        // Credits are exhausted; return two, then 12 must beat 5 if rr_ptr sits at 11.
        fif.fetch_return_en = 1'b1;
        tick();
        tick();
        fif.fetch_return_en = 1'b0;
        wave_valid_entries = (40'h1 << 5) | (40'h1 << 12);
        tick();
        wave_valid_entries = '0;
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd12) begin
            errors++; $display("FAIL rr_ptr_end: got %0b/%0d expected 1/12", fif.fetch_valid, fif.fetch_wfid);
        end
    endtask

    task automatic test_stall_withdraw();
        do_reset();
        fif.fetch_ready = 1'b0;
        dispatch_en = 1'b1; dispatch_wfid = 6'd7;
        tick();
        dispatch_en = 1'b0;
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd7) begin
            errors++; $display("FAIL stall_load: got %0b/%0d expected 1/7", fif.fetch_valid, fif.fetch_wfid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd7 || pending_bitmap !== 40'h80) begin
                errors++; $display("FAIL stall_hold: got %0b/%0d/%h expected 1/7/80", fif.fetch_valid, fif.fetch_wfid, pending_bitmap);
            end
        end
        dealloc_en = 1'b1; dealloc_wfid = 6'd7;
        tick();
        dealloc_en = 1'b0;
        checks++;
        if (fif.fetch_valid !== 1'b0 || pending_bitmap !== 40'h0) begin
            errors++; $display("FAIL stall_withdraw: got %0b/%h expected 0/0", fif.fetch_valid, pending_bitmap);
        end
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_stays_idle: got %0b expected 0", fif.fetch_valid); end
    endtask

    task automatic test_credit_limit();
        int cnt;
        do_reset();
        fif.fetch_ready = 1'b1;
        cnt = 0;
        wave_valid_entries = 40'h3F;
        for (int i = 0; i < 10; i++) begin
            tick();
            wave_valid_entries = '0;
            if (fif.fetch_valid && fif.fetch_ready) cnt++;
        end
        checks++;
        if (cnt != 4) begin errors++; $display("FAIL credit_grants: got %0d expected 4", cnt); end
        checks++;
        if (fif.fetch_valid !== 1'b0 || pending_bitmap !== 40'h30) begin
            errors++; $display("FAIL credit_block: got %0b/%h expected 0/30", fif.fetch_valid, pending_bitmap);
        end
        cnt = 0;
        fif.fetch_return_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            fif.fetch_return_en = 1'b0;
            if (fif.fetch_valid && fif.fetch_ready) cnt++;
        end
        checks++;
        if (cnt != 1 || pending_bitmap !== 40'h20) begin
            errors++; $display("FAIL credit_return_grant: got %0d/%h expected 1/20", cnt, pending_bitmap);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        fif.fetch_ready = 1'b1;
        wave_valid_entries = 40'h4;
        tick();
        wave_valid_entries = '0;
        tick();
        checks++;
        if (fif.fetch_valid !== 1'b1 || fif.fetch_wfid !== 6'd2) begin
            errors++; $display("FAIL same_first: got %0b/%0d expected 1/2", fif.fetch_valid, fif.fetch_wfid);
        end
        wave_valid_entries = (40'h1 << 0) | (40'h1 << 2) | (40'h1 << 20);
        tick();
        wave_valid_entries = '0;
        checks++;
        if (pending_bitmap !== 40'h100005 || fif.fetch_valid !== 1'b0) begin
            errors++; $display("FAIL same_pending: got %h/%0b expected 100005/0", pending_bitmap, fif.fetch_valid);
        end
        tick();
        checks++;
        if (fif.fetch_wfid !== 6'd20 || fif.fetch_valid !== 1'b1) begin
            errors++; $display("FAIL same_order20: got %0b/%0d expected 1/20", fif.fetch_valid, fif.fetch_wfid);
        end
        tick();
        checks++;
        if (fif.fetch_wfid !== 6'd0 || fif.fetch_valid !== 1'b1) begin
            errors++; $display("FAIL same_order0: got %0b/%0d expected 1/0", fif.fetch_valid, fif.fetch_wfid);
        end
        tick();
        checks++;
        if (fif.fetch_wfid !== 6'd2 || fif.fetch_valid !== 1'b1) begin
            errors++; $display("FAIL same_regrant2: got %0b/%0d expected 1/2", fif.fetch_valid, fif.fetch_wfid);
        end
    endtask

    task automatic test_credit_err();
        int cnt;
        do_reset();
        fif.fetch_ready = 1'b1;
        checks++;
        if (credit_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %0b expected 0", credit_err); end
        fif.fetch_return_en = 1'b1;
        tick();
        fif.fetch_return_en = 1'b0;
        checks++;
        if (credit_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", credit_err); end
        // Counter must have saturated at 4, not grown or wrapped.
        cnt = 0;
        wave_valid_entries = 40'h3F;
        for (int i = 0; i < 10; i++) begin
            tick();
            wave_valid_entries = '0;
            if (fif.fetch_valid && fif.fetch_ready) cnt++;
        end
        checks++;
        if (cnt != 4) begin errors++; $display("FAIL err_saturate: got %0d grants expected 4", cnt); end
        checks++;
        if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", credit_err); end
        do_reset();
        checks++;
        if (credit_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b expected 0", credit_err); end
    endtask

    initial begin
        rst                 = 1'b1;
        wave_valid_entries  = '0;
        dispatch_en         = 1'b0;
        dispatch_wfid       = '0;
        dealloc_en          = 1'b0;
        dealloc_wfid        = '0;
        fif.fetch_ready     = 1'b0;
        fif.fetch_return_en = 1'b0;
        tick();
        test_reset();
        test_dispatch();
        test_rr_order();
        test_stall_withdraw();
        test_credit_limit();
        test_same_cycle();
        test_credit_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_fetch_scheduler.md
Name: wave_fetch_scheduler

Overview:
- Collects per-wavefront "needs next instruction" requests from issue flow control (wave_valid_entries) and from new-wavefront dispatch.
- Holds them in a pending bitmap and round-robin arbitrates one wavefront per cycle into a valid/ready fetch request channel.
- Throttles requests with a credit counter bounding outstanding fetches.
- Sits between the issue stage and the fetch unit.

Parameters:
- WF_PER_CU, 40, number of wavefront slots (global definition).
- WF_ID_LENGTH, 6, wavefront id width (global definition).
- MAX_OUTSTANDING, 4, maximum fetches issued but not yet returned (1..15).
- CREDIT_W, 4, credit counter width; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wave_valid_entries  in  WF_PER_CU  one-cycle request pulses, one bit per wavefront.
- dispatch_en  in  1  new wavefront allocated.
- dispatch_wfid  in  WF_ID_LENGTH  id of the allocated wavefront.
- dealloc_en  in  1  wavefront retired or killed.
- dealloc_wfid  in  WF_ID_LENGTH  id of the retired or killed wavefront.
- fetch_ready  in  1  fetch unit accepts the presented request.
- fetch_return_en  in  1  one outstanding fetch completed; returns one credit.
- fetch_valid  out  1  request presented.
- fetch_wfid  out  WF_ID_LENGTH  wavefront id of the presented request.
- pending_bitmap  out  WF_PER_CU  current pending register, for debug and tracemon.
- credit_err  out  1  sticky flag: a credit was returned while the counter was full.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high at a posedge:
  - pending=0, fetch_valid=0, fetch_wfid=0;
  - credits=MAX_OUTSTANDING, rr_ptr=0, credit_err=0.
  - Reset mid-transfer drops any presented request without acceptance and does not return credits.
- Accept: a handshake occurs on a cycle with fetch_valid & fetch_ready.
- Pending update each cycle, applied in this order:
  - set_vec = wave_valid_entries | onehot(dispatch_wfid if dispatch_en).
  - clr_vec = onehot(fetch_wfid if accept) | onehot(dealloc_wfid if dealloc_en).
  - pending_next = (pending & ~onehot(accepted wfid)) | set_vec, then & ~onehot(dealloc).
  - Set and accept-clear on the same wavefront in the same cycle leave it pending; this is a new request.
  - Dealloc always wins over set.
  - Ids >= WF_PER_CU are ignored.
- Candidate eligibility: pending bits, excluding the wavefront currently held in the output register while fetch_valid=1.
- Arbitration, combinational from registered state:
  - Search eligible bits starting at rr_ptr, ascending, wrapping 39 -> 0.
  - First hit is the winner.
  - rr_ptr <= winner+1 (39+1 wraps to 0), updated only when the winner is loaded into the output register.
- Output register load condition: (fetch_valid==0 | accept) & winner exists & credits_avail.
  - credits_avail = (credits - accept) > 0, so a slot freed by the current accept counts.
  - On load: fetch_valid<=1, fetch_wfid<=winner.
  - Else, on accept: fetch_valid<=0.
  - Else: hold. fetch_wfid stays stable while valid & !ready.
- Withdraw: if dealloc_en & dealloc_wfid==fetch_wfid & fetch_valid & !fetch_ready, then fetch_valid<=0 next cycle. A same-cycle accept still counts as accepted.
- Credits:
  - credits_next = credits - accept + fetch_return_en; simultaneous accept and return gives net 0.
  - Return when credits==MAX_OUTSTANDING and no accept: saturate and set credit_err (cleared only by rst).
  - Accept is impossible at credits==0 by construction.
- Latency: wave_valid_entries pulse at cycle N -> pending bit visible N+1 -> fetch_valid earliest N+2 (idle arbiter, credits>0).
- Throughput: with fetch_ready held high and credits available, one request per cycle.

Decomposition:
- Shared definitions package: WF_PER_CU, WF_ID_LENGTH, and the credit width constant.
- Reuse the existing enabled 6-to-40 decoder for the dispatch, dealloc and accept one-hots.
- Sub-module rr_priority_picker_40: rotate by rr_ptr, priority-encode, un-rotate. Outputs winner id and hit flag.
- Top level holds the pending register, output register, credit counter and withdraw logic.

Test Plan:
- Reset then dispatch wfid 5; fetch_ready=1 -> fetch_valid=1, fetch_wfid=5 two cycles later; pending clears after accept; credits 4->3.
- Pulse wave_valid_entries bits 3, 10, 39 together; rr_ptr=11; ready=1 -> grants in order 39, 3, 10; rr_ptr ends at 11.
- fetch_ready=0 for 5 cycles with wfid 7 presented -> fetch_wfid stays 7 and valid stays 1; dealloc wfid 7 in cycle 3 -> valid drops next cycle; pending[7]=0.
- MAX_OUTSTANDING=4, 6 wavefronts pending, ready=1, no returns -> exactly 4 grants, then fetch_valid=0; one fetch_return_en -> exactly one more grant.
- Same cycle: accept wfid 2 and wave_valid_entries[2]=1 -> pending[2] remains 1, and 2 is granted again after other eligible wavefronts in round-robin order.
- credits=4, fetch_return_en with no accept -> credits stays 4 and credit_err=1 until rst.
